// File: rtl/sha_msg_loader_if.sv
// Message-stream input and block-memory write port bundle for sha_msg_loader.
// The loader connects through the master modport; the feeding side and memory use slave.
interface sha_msg_loader_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 16,
    parameter int BW_W   = 9
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              cs_n;
    logic              wr_n;
    logic              rd_n;
    logic [ADDR_W-1:0] addr;
    logic [BW_W-1:0]   addr_width;
    logic [WORD_W-1:0] bram_data_in;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] n_blocks;

    modport master (
        input  start, base_addr, in_valid, in_data, in_last,
        output in_ready, cs_n, wr_n, rd_n, addr, addr_width, bram_data_in,
               done, error, n_blocks
    );

    modport slave (
        output start, base_addr, in_valid, in_data, in_last,
        input  in_ready, cs_n, wr_n, rd_n, addr, addr_width, bram_data_in,
               done, error, n_blocks
    );
endinterface

// File: rtl/sha_msg_loader.sv
// Packs a stream of message words into BLOCK_W-bit memory rows, optionally
// appending SHA-256 padding and the 64-bit big-endian message bit length.
module sha_msg_loader #(
    parameter int WORD_W     = 32,
    parameter int BLOCK_W    = 512,
    parameter int ADDR_W     = 16,
    parameter int MAX_BLOCKS = 256,
    parameter int PAD_EN     = 1
) (
    input  logic             clock,
    input  logic             reset,
    sha_msg_loader_if.master bus
);
    localparam int BW_W      = $clog2(BLOCK_W);
    localparam int WPB       = BLOCK_W / WORD_W;
    localparam int LEN_WORDS = 64 / WORD_W;
    localparam int WIDX_W    = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int BLK_W     = $clog2(MAX_BLOCKS + 1);

    localparam logic [WORD_W-1:0] PAD_WORD  = {1'b1, {(WORD_W-1){1'b0}}};
    localparam logic [WIDX_W-1:0] LEN_START = WIDX_W'(WPB - LEN_WORDS);
    localparam logic [WIDX_W-1:0] LAST_IDX  = WIDX_W'(WPB - 1);
    localparam logic [BLK_W-1:0]  BLK_LIMIT = BLK_W'(MAX_BLOCKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAD,
        S_ZERO,
        S_LEN,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [WIDX_W-1:0] r_widx;
    logic [BLK_W-1:0]  r_blk;
    logic [63:0]       r_bitCnt;
    logic              r_inReady;
    logic              r_csN;
    logic              r_wrN;
    logic [ADDR_W-1:0] r_addr;
    logic [BW_W-1:0]   r_addrWidth;
    logic [WORD_W-1:0] r_data;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W-1:0] r_nBlocks;

    logic              w_issue;
    logic [WORD_W-1:0] w_wrData;
    logic              w_lastInRow;
    logic              w_atLimit;
    logic [WIDX_W-1:0] w_widxNext;
    logic [BLK_W-1:0]  w_blkNext;
    logic [ADDR_W-1:0] w_addr;
    logic [BW_W-1:0]   w_width;

    assign w_lastInRow = (r_widx == LAST_IDX);
    assign w_widxNext  = w_lastInRow ? '0 : r_widx + WIDX_W'(1);
    assign w_blkNext   = w_lastInRow ? r_blk + BLK_W'(1) : r_blk;
    assign w_atLimit   = (r_blk == BLK_LIMIT);
    assign w_addr      = r_base + ADDR_W'(r_blk);
    assign w_width     = BW_W'(BLOCK_W - 1 - WORD_W * int'(r_widx));

    // Which word, if any, goes to memory this cycle; the length field is
    // shifted out of the top of the bit counter one word at a time.
    always_comb begin
        w_issue  = 1'b0;
        w_wrData = '0;
        case (r_state)
            S_LOAD: begin
                w_issue  = bus.in_valid & r_inReady;
                w_wrData = bus.in_data;
            end
            S_PAD: begin
                w_issue  = 1'b1;
                w_wrData = PAD_WORD;
            end
            S_ZERO: begin
                w_issue  = 1'b1;
            end
            S_LEN: begin
                w_issue  = 1'b1;
                w_wrData = r_bitCnt[63 -: WORD_W];
            end
            default: begin
                w_issue  = 1'b0;
            end
        endcase
    end

    // A write aimed at row MAX_BLOCKS is dropped and the message aborts with error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_widx      <= '0;
            r_blk       <= '0;
            r_bitCnt    <= '0;
            r_inReady   <= 1'b0;
            r_csN       <= 1'b1;
            r_wrN       <= 1'b1;
            r_addr      <= '0;
            r_addrWidth <= BW_W'(BLOCK_W - 1);
            r_data      <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_nBlocks   <= '0;
        end else begin
            r_csN <= 1'b1;
            r_wrN <= 1'b1;

            if (w_issue && w_atLimit) begin
                r_error   <= 1'b1;
                r_inReady <= 1'b0;
                r_state   <= S_DONE;
            end else if (w_issue) begin
                r_csN       <= 1'b0;
                r_wrN       <= 1'b0;
                r_addr      <= w_addr;
                r_addrWidth <= w_width;
                r_data      <= w_wrData;
                r_widx      <= w_widxNext;
                r_blk       <= w_blkNext;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_state == S_DONE) begin
                        r_done    <= 1'b1;
                        r_nBlocks <= ADDR_W'(r_blk);
                    end
                    if (bus.start) begin
                        r_base    <= bus.base_addr;
                        r_widx    <= '0;
                        r_blk     <= '0;
                        r_bitCnt  <= '0;
                        r_done    <= 1'b0;
                        r_error   <= 1'b0;
                        r_nBlocks <= '0;
                        r_inReady <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_issue && !w_atLimit) begin
                        r_bitCnt <= r_bitCnt + 64'(WORD_W);
                        if (bus.in_last) begin
                            r_inReady <= 1'b0;
                            if (PAD_EN != 0)
                                r_state <= S_PAD;
                            else if (w_widxNext != '0)
                                r_state <= S_ZERO;
                            else
                                r_state <= S_DONE;
                        end
                    end
                end
                S_PAD: begin
                    if (!w_atLimit)
                        r_state <= (w_widxNext == LEN_START) ? S_LEN : S_ZERO;
                end
                S_ZERO: begin
                    if (!w_atLimit) begin
                        if (PAD_EN != 0) begin
                            if (w_widxNext == LEN_START)
                                r_state <= S_LEN;
                        end else if (w_lastInRow) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_LEN: begin
                    if (!w_atLimit) begin
                        r_bitCnt <= r_bitCnt << WORD_W;
                        if (w_lastInRow)
                            r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = r_inReady;
    assign bus.cs_n         = r_csN;
    assign bus.wr_n         = r_wrN;
    assign bus.rd_n         = 1'b1;
    assign bus.addr         = r_addr;
    assign bus.addr_width   = r_addrWidth;
    assign bus.bram_data_in = r_data;
    assign bus.done         = r_done;
    assign bus.error        = r_error;
    assign bus.n_blocks     = r_nBlocks;
endmodule

// File: tb/tb_sha_msg_loader.sv
// Directed bench for sha_msg_loader: three instances (padded, unpadded, one-block limit)
// share one input stream; the instance selected by sel is captured and checked.
module tb_sha_msg_loader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] baseAddr = '0;
    logic        inValid = 1'b0;
    logic [31:0] inData = '0;
    logic        inLast = 1'b0;
    int          sel = 0;

    always #5 clock = ~clock;

    sha_msg_loader_if #(.WORD_W(32), .ADDR_W(16), .BW_W(9)) busA ();
    sha_msg_loader_if #(.WORD_W(32), .ADDR_W(16), .BW_W(9)) busB ();
    sha_msg_loader_if #(.WORD_W(32), .ADDR_W(16), .BW_W(9)) busC ();

    assign busA.start = start;    assign busB.start = start;    assign busC.start = start;
    assign busA.base_addr = baseAddr; assign busB.base_addr = baseAddr; assign busC.base_addr = baseAddr;
    assign busA.in_valid = inValid; assign busB.in_valid = inValid; assign busC.in_valid = inValid;
    assign busA.in_data = inData;  assign busB.in_data = inData;  assign busC.in_data = inData;
    assign busA.in_last = inLast;  assign busB.in_last = inLast;  assign busC.in_last = inLast;

    sha_msg_loader #(.WORD_W(32), .BLOCK_W(512), .ADDR_W(16), .MAX_BLOCKS(256), .PAD_EN(1))
        dutPad (.clock(clock), .reset(reset), .bus(busA));
    sha_msg_loader #(.WORD_W(32), .BLOCK_W(512), .ADDR_W(16), .MAX_BLOCKS(256), .PAD_EN(0))
        dutNoPad (.clock(clock), .reset(reset), .bus(busB));
    sha_msg_loader #(.WORD_W(32), .BLOCK_W(512), .ADDR_W(16), .MAX_BLOCKS(1), .PAD_EN(1))
        dutMax1 (.clock(clock), .reset(reset), .bus(busC));

    logic        obsReady, obsCsN, obsWrN, obsRdN, obsDone, obsError;
    logic [15:0] obsAddr, obsNBlocks;
    logic [8:0]  obsWidth;
    logic [31:0] obsData;

    // Route the selected instance's outputs to the observation signals.
    always_comb begin
        case (sel)
            1: begin
                obsReady = busB.in_ready; obsCsN = busB.cs_n; obsWrN = busB.wr_n; obsRdN = busB.rd_n;
                obsDone = busB.done; obsError = busB.error; obsAddr = busB.addr;
                obsNBlocks = busB.n_blocks; obsWidth = busB.addr_width; obsData = busB.bram_data_in;
            end
            2: begin
                obsReady = busC.in_ready; obsCsN = busC.cs_n; obsWrN = busC.wr_n; obsRdN = busC.rd_n;
                obsDone = busC.done; obsError = busC.error; obsAddr = busC.addr;
                obsNBlocks = busC.n_blocks; obsWidth = busC.addr_width; obsData = busC.bram_data_in;
            end
            default: begin
                obsReady = busA.in_ready; obsCsN = busA.cs_n; obsWrN = busA.wr_n; obsRdN = busA.rd_n;
                obsDone = busA.done; obsError = busA.error; obsAddr = busA.addr;
                obsNBlocks = busA.n_blocks; obsWidth = busA.addr_width; obsData = busA.bram_data_in;
            end
        endcase
    end

    int totalCnt = 0;
    int badCnt = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        if (obs !== exp) begin
            badCnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write capture on the falling edge, plus cycle bookkeeping for done latency.
    int          cycleCnt = 0;
    int          lastWrCycle = 0;
    int          doneCycle = 0;
    int          rdNBad = 0;
    logic [15:0] capAddr[$];
    logic [8:0]  capWidth[$];
    logic [31:0] capData[$];
    logic [15:0] expAddr[$];
    logic [8:0]  expWidth[$];
    logic [31:0] expData[$];
    logic [31:0] msgWords[0:31];

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    always @(negedge clock) begin
        if (!reset && obsCsN === 1'b0 && obsWrN === 1'b0) begin
            capAddr.push_back(obsAddr);
            capWidth.push_back(obsWidth);
            capData.push_back(obsData);
            lastWrCycle = cycleCnt;
        end
        if (obsRdN !== 1'b1) rdNBad++;
    end

    task automatic addExp(input logic [15:0] a, input int w, input logic [31:0] d);
        expAddr.push_back(a);
        expWidth.push_back(9'(w));
        expData.push_back(d);
    endtask

    task automatic clearExp();
        expAddr.delete();
        expWidth.delete();
        expData.delete();
    endtask

    task automatic pushWord(input logic [31:0] d, input bit last);
        int t = 0;
        inValid = 1'b1;
        inData  = d;
        inLast  = last;
        while (obsReady !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) checkOutput("readyWait", obsReady, 1);
        @(negedge clock);
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] base, input int n, input int gapMax);
        capAddr.delete();
        capWidth.delete();
        capData.delete();
        @(negedge clock);
        start    = 1'b1;
        baseAddr = base;
        @(negedge clock);
        start    = 1'b0;
        checkOutput("startReady", obsReady, 1);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
            repeat (gap) @(negedge clock);
            pushWord(msgWords[i], (i == n - 1));
        end
    endtask

    task automatic waitDone(input string tag);
        int t = 0;
        while (obsDone !== 1'b1 && t < 300) begin
            @(negedge clock);
            t++;
        end
        doneCycle = cycleCnt;
        checkOutput({tag, ".done"}, obsDone, 1);
    endtask

    task automatic checkWrites(input string tag);
        int n;
        checkOutput({tag, ".count"}, capAddr.size(), expAddr.size());
        n = (capAddr.size() < expAddr.size()) ? capAddr.size() : expAddr.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s.addr[%0d]", tag, i), capAddr[i], expAddr[i]);
            checkOutput($sformatf("%s.width[%0d]", tag, i), capWidth[i], expWidth[i]);
            checkOutput($sformatf("%s.data[%0d]", tag, i), capData[i], expData[i]);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".cs_n"}, obsCsN, 1);
        checkOutput({tag, ".wr_n"}, obsWrN, 1);
        checkOutput({tag, ".rd_n"}, obsRdN, 1);
        checkOutput({tag, ".addr"}, obsAddr, 0);
        checkOutput({tag, ".width"}, obsWidth, 511);
        checkOutput({tag, ".data"}, obsData, 0);
        checkOutput({tag, ".ready"}, obsReady, 0);
        checkOutput({tag, ".done"}, obsDone, 0);
        checkOutput({tag, ".error"}, obsError, 0);
        checkOutput({tag, ".nblocks"}, obsNBlocks, 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        checkResetState("rst");
        reset = 1'b0;
        @(negedge clock);

        // One word, padded: a single row ending in length 32.
        sel = 0;
        msgWords[0] = 32'hDEADBEEF;
        applyStimulus(16'h0000, 1, 0);
        waitDone("t1");
        clearExp();
        addExp(16'h0, 511, 32'hDEADBEEF);
        addExp(16'h0, 479, 32'h80000000);
        for (int k = 2; k < 14; k++) addExp(16'h0, 511 - 32 * k, 32'h0);
        addExp(16'h0, 63, 32'h0);
        addExp(16'h0, 31, 32'h20);
        checkWrites("t1");
        checkOutput("t1.nblocks", obsNBlocks, 1);
        checkOutput("t1.error", obsError, 0);
        checkOutput("t1.doneLat", doneCycle - lastWrCycle, 1);
        checkOutput("t1.readyLow", obsReady, 0);
        repeat (40) @(negedge clock);

        // Sixteen words from base 0x40: padding spills into a full second row.
        for (int k = 0; k < 32; k++) msgWords[k] = $urandom & 32'h7FFFFFFF;
        applyStimulus(16'h0040, 16, 0);
        waitDone("t2");
        clearExp();
        for (int k = 0; k < 16; k++) addExp(16'h40, 511 - 32 * k, msgWords[k]);
        addExp(16'h41, 511, 32'h80000000);
        for (int k = 1; k < 14; k++) addExp(16'h41, 511 - 32 * k, 32'h0);
        addExp(16'h41, 63, 32'h0);
        addExp(16'h41, 31, 32'h200);
        checkWrites("t2");
        checkOutput("t2.nblocks", obsNBlocks, 2);
        checkOutput("t2.doneLat", doneCycle - lastWrCycle, 1);
        repeat (40) @(negedge clock);

        // Fourteen words: pad lands in the length slot, forcing a second row.
        applyStimulus(16'h0000, 14, 0);
        waitDone("t3");
        clearExp();
        for (int k = 0; k < 14; k++) addExp(16'h0, 511 - 32 * k, msgWords[k]);
        addExp(16'h0, 63, 32'h80000000);
        addExp(16'h0, 31, 32'h0);
        for (int k = 0; k < 14; k++) addExp(16'h1, 511 - 32 * k, 32'h0);
        addExp(16'h1, 63, 32'h0);
        addExp(16'h1, 31, 32'h1C0);
        checkWrites("t3");
        checkOutput("t3.nblocks", obsNBlocks, 2);
        repeat (40) @(negedge clock);

        // Unpadded instance, twenty words with random in_valid gaps.
        sel = 1;
        applyStimulus(16'h0000, 20, 3);
        waitDone("t4");
        clearExp();
        for (int k = 0; k < 16; k++) addExp(16'h0, 511 - 32 * k, msgWords[k]);
        for (int k = 0; k < 4; k++) addExp(16'h1, 511 - 32 * k, msgWords[16 + k]);
        for (int k = 4; k < 16; k++) addExp(16'h1, 511 - 32 * k, 32'h0);
        checkWrites("t4");
        checkOutput("t4.nblocks", obsNBlocks, 2);
        checkOutput("t4.doneLat", doneCycle - lastWrCycle, 1);
        repeat (40) @(negedge clock);

        // One-block limit: the padding write overflows and is suppressed.
        sel = 2;
        applyStimulus(16'h0000, 16, 0);
        waitDone("t5");
        clearExp();
        for (int k = 0; k < 16; k++) addExp(16'h0, 511 - 32 * k, msgWords[k]);
        repeat (5) @(negedge clock);
        checkWrites("t5");
        checkOutput("t5.error", obsError, 1);
        checkOutput("t5.nblocks", obsNBlocks, 1);
        checkOutput("t5.readyLow", obsReady, 0);
        repeat (40) @(negedge clock);

        // Asynchronous reset in the middle of a row, then a clean reload at 0x10.
        sel = 0;
        applyStimulus(16'h0000, 0, 0);
        for (int k = 0; k < 5; k++) pushWord(msgWords[k], 1'b0);
        checkOutput("t6.midWrite", obsCsN, 0);
        reset = 1'b1;
        #1;
        checkResetState("t6.rst");
        @(negedge clock);
        reset = 1'b0;
        msgWords[0] = 32'h12345678;
        applyStimulus(16'h0010, 1, 0);
        waitDone("t6");
        checkOutput("t6.count", capAddr.size(), 16);
        checkOutput("t6.firstAddr", capAddr[0], 16'h10);
        checkOutput("t6.firstWidth", capWidth[0], 511);
        checkOutput("t6.firstData", capData[0], 32'h12345678);
        checkOutput("t6.lenData", capData[15], 32'h20);
        checkOutput("t6.nblocks", obsNBlocks, 1);

        checkOutput("rdN.neverLow", rdNBad, 0);
        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end
endmodule

// File: doc/sha_msg_loader.md
# sha_msg_loader

Parametrised message loader for the mining datapath. It accepts a stream of message words, packs them into BLOCK_W-bit rows of the block memory through the existing cs_n/wr_n/rd_n/addr/addr_width write port, and optionally appends SHA-256 padding and the 64-bit length field. It replaces the fixed 16×32-bit bench-driven load sequence, feeding Mining_FSM and SHA_256 with complete padded blocks of any length up to MAX_BLOCKS.

## Interface
- WORD_W, 32, input/memory word width; 32 or 64 only.
- BLOCK_W, 512, row width; a multiple of WORD_W. WPB = BLOCK_W/WORD_W.
- ADDR_W, 16, memory address width.
- MAX_BLOCKS, 256, largest permitted block count per message.
- PAD_EN, 1, 1 = SHA-256 padding and length; 0 = zero-fill the final row only.
- BW_W = $clog2(BLOCK_W), derived (9 for 512).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a new message.
- base_addr  in  ADDR_W  first row address, sampled on an accepted start.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  WORD_W  message word, big-endian.
- in_last  in  1  final message word, qualified by in_valid.
- cs_n, wr_n, rd_n  out  1 each  memory strobes; rd_n is always 1.
- addr  out  ADDR_W  row address.
- addr_width  out  BW_W  MSB bit index of the word within the row.
- bram_data_in  out  WORD_W  write data.
- done  out  1  message fully written.
- error  out  1  MAX_BLOCKS exceeded.
- n_blocks  out  ADDR_W  rows written, valid while done=1.

## Operation
- States: IDLE, LOAD, PAD, ZERO, LEN, DONE.
- **IDLE / DONE.** An accepted start latches base_addr, clears the word index (widx), block counter, bit counter, done and error, then moves to LOAD. start in any other state is ignored.
- **LOAD.** in_ready=1. Each in_valid&in_ready handshake issues one write:
  - data = in_data, addr = base_addr + blk, addr_width = BLOCK_W-1 - WORD_W*widx.
  - The bit counter (64-bit) adds WORD_W.
  - widx wraps at WPB-1, at which point blk increments.
- **Leaving LOAD on in_last.**
  - PAD_EN=1: go to PAD.
  - PAD_EN=0: go to ZERO if widx≠0 after the last word, otherwise go to DONE.
- **PAD.** One write of {1'b1, zeros}, i.e. 0x80000000 for WORD_W=32.
- **ZERO.** Zero words are written.
  - PAD_EN=1: ZERO runs until widx == WPB - 64/WORD_W. If the PAD word left widx beyond that point, ZERO fills to the end of the row and continues into the next row.
  - PAD_EN=0: ZERO runs to the end of the row.
- **LEN.** Writes the 64-bit bit count big-endian over 64/WORD_W words (high word first for 32-bit), then goes to DONE.
- **DONE.**
  - done=1.
  - n_blocks = blk.
  - Outputs hold until the next start.
- **Overflow.** Any write that would target blk == MAX_BLOCKS is suppressed. error=1 and the FSM goes to DONE with n_blocks = MAX_BLOCKS; no further input is accepted.
- in_ready=0 in every state except LOAD. Words presented outside LOAD are not consumed.

## Timing
- **Reset values.**
  - cs_n=1, wr_n=1, rd_n=1.
  - addr=0, addr_width=BLOCK_W-1, bram_data_in=0.
  - in_ready=0, done=0, error=0, n_blocks=0.
  - State=IDLE.
- **Write strobes.** All outputs are registered. A handshake on edge N produces cs_n=wr_n=0 with valid addr, addr_width and data during cycle N+1, for exactly one cycle per word. Memory writes on the following edge.
- **Start latency.** start on edge N gives in_ready=1 from cycle N+1.
- **Throughput.** One word per cycle in every state. PAD, ZERO and LEN emit back-to-back writes with no bubbles. in_valid gaps simply produce no write.
- **done timing.** done rises the cycle after the final write strobe.
- **Reset mid-operation.** All outputs return to reset values immediately and asynchronously. Any partial row is abandoned.

## Test plan
- **One word, 0xDEADBEEF, last, PAD_EN=1, base 0:** 16 writes to addr 0.
  - widths 511..31.
  - data 0xDEADBEEF, 0x80000000, 12×0, then 0x00000000, 0x00000020.
  - Then n_blocks=1, done=1.
- **16 words, random:** 32 writes.
  - Row 0 holds the data.
  - Row 1 holds 0x80000000 at width 511, zeros, and length 0x00000000 / 0x00000200 at widths 63 / 31.
  - n_blocks=2.
- **14 words:** row 0 holds 14 data words, then 0x80000000 at width 63 and 0 at width 31.
  - Row 1 holds 14 zeros and length 0x000001C0.
  - n_blocks=2.
- **PAD_EN=0, 20 words with random in_valid gaps:** data writes occur only on handshakes.
  - Row 1 holds 4 data words plus 12 zeros.
  - n_blocks=2; no 0x80000000 or length word anywhere.
- **MAX_BLOCKS=1, 16 words, PAD_EN=1:** the row 0 writes complete, with no write at addr 1.
  - error=1, done=1, n_blocks=1.
- **Reset asserted after 5 words:** outputs return to reset values that same cycle.
  - A subsequent start with base_addr=0x10 reloads correctly, with first write at addr 0x10, width 511.
